part_2_trgt_vec_apply: RTL

- Synthesizable stage directly downstream of the target co-sim interface, on the DUT side of the partition.
- Buffers the received per-channel input vectors ({wen, data[7:0]}, each with a valid strobe) in small FIFOs.
- Applies one vector per channel to the partition inputs on each mission-clock rising edge, sampled in the utility clock domain.
- Drives per-channel freeze requests while any channel is starved, plus watchdog and overrun error flags.

---
 rtl/part_2_trgt_vec_apply_if.sv | 11 +
 rtl/part_2_trgt_vec_apply.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/part_2_trgt_vec_apply_if.sv
// part_2_trgt_vec_apply_if: receive-side vector bundle from the co-sim target interface
//   rcv_valid  per-channel vector strobe, one cycle per vector
//   rcv_data   channel c at [c*DW +: DW], bit DW-1 = wen, bits 7:0 = data
//   rcv_ready  per-channel FIFO not full
interface part_2_trgt_vec_apply_if #(parameter int NCH = 3, parameter int DW = 9);
  logic [NCH-1:0] rcv_valid;
  logic [NCH*DW-1:0] rcv_data;
  logic [NCH-1:0] rcv_ready;
  modport master (output rcv_valid, rcv_data, input rcv_ready);
  modport slave (input rcv_valid, rcv_data, output rcv_ready);
endinterface

// File: rtl/part_2_trgt_vec_apply.sv
// part_2_trgt_vec_apply: buffers received vectors and applies one per channel on each mission-clock edge
//   clk_i/rst_ni   utility clock, async active-low reset (sync release)
//   mclk_i         mission clock, only sampled
//   rcv            vector receive bundle (slave)
//   wen_o/data_o   applied vectors, apply_o pulses when they change
//   freeze_clk_o   per-channel starvation request
//   wdog_err_o     sticky watchdog timeout, ovr_err_o sticky overrun/drop
module part_2_trgt_vec_apply #(
  parameter int NCH = 3,
  parameter int DW = 9,
  parameter int DEPTH = 4,
  parameter int WDOG_MAX = 10000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mclk_i,
  part_2_trgt_vec_apply_if.slave rcv,
  output logic [NCH-1:0] wen_o,
  output logic [NCH*8-1:0] data_o,
  output logic apply_o,
  output logic [NCH-1:0] freeze_clk_o,
  output logic wdog_err_o,
  output logic ovr_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(WDOG_MAX);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, ERROR} state_e;
  state_e state_q, state_d;
  logic [1:0] rs_q;
  logic rst_sync_n;
  logic [2:0] sync_q, sync_d;
  logic tick, all_ne;
  logic [DW-1:0] mem_q [NCH][DEPTH];
  logic [DW-1:0] mem_d [NCH][DEPTH];
  logic [AW:0] wp_q [NCH];
  logic [AW:0] wp_d [NCH];
  logic [AW:0] rp_q [NCH];
  logic [AW:0] rp_d [NCH];
  logic [NCH-1:0] full, empty, push, pop;
  logic [WW-1:0] wdog_q, wdog_d;
  logic [NCH-1:0] wen_q, wen_d, frz_q, frz_d;
  logic [NCH*8-1:0] data_q, data_d;
  logic apply_q, apply_d, wdog_err_q, wdog_err_d, ovr_q, ovr_d;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) rs_q <= '0;
    else rs_q <= {rs_q[0], 1'b1};
  assign rst_sync_n = rs_q[1];
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      empty[c] = wp_q[c] == rp_q[c];
      full[c] = (wp_q[c] ^ rp_q[c]) == (AW+1)'(DEPTH);
    end
  end
  assign push = rcv.rcv_valid & ~full;
  assign rcv.rcv_ready = ~full;
  assign all_ne = ~|empty;
  assign tick = sync_q[1] & ~sync_q[2];
  always_comb begin
    state_d = state_q;
    sync_d = {sync_q[1:0], mclk_i};
    mem_d = mem_q;
    wp_d = wp_q;
    rp_d = rp_q;
    wdog_d = wdog_q;
    wen_d = wen_q;
    data_d = data_q;
    frz_d = frz_q;
    wdog_err_d = wdog_err_q;
    ovr_d = ovr_q | |(rcv.rcv_valid & full);
    pop = '0;
    case (state_q)
      IDLE: if (tick) begin
        if (!all_ne) begin
          state_d = WAIT_DATA;
          wdog_d = '0;
        end else if (apply_q) ovr_d = 1'b1;  // edge landed on the cycle right after an apply: missed
        else pop = '1;
      end
      WAIT_DATA: begin
        ovr_d = ovr_d | tick;
        if (all_ne) begin
          pop = '1;
          frz_d = '0;
          state_d = IDLE;
        end else if (wdog_q == WW'(WDOG_MAX - 1)) begin
          wdog_err_d = 1'b1;
          frz_d = '1;
          state_d = ERROR;
        end else begin
          frz_d = empty;
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: frz_d = '1;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem_d[c][wp_q[c][AW-1:0]] = rcv.rcv_data[c*DW +: DW];
        wp_d[c] = wp_q[c] + 1'b1;
      end
      if (pop[c]) begin
        rp_d[c] = rp_q[c] + 1'b1;
        wen_d[c] = mem_q[c][rp_q[c][AW-1:0]][DW-1];
        data_d[c*8 +: 8] = mem_q[c][rp_q[c][AW-1:0]][7:0];
      end
    end
    apply_d = |pop;
  end
  always_ff @(posedge clk_i or negedge rst_sync_n)
    if (!rst_sync_n) begin
      state_q <= IDLE;
      sync_q <= '0;
      mem_q <= '{default: '0};
      wp_q <= '{default: '0};
      rp_q <= '{default: '0};
      wdog_q <= '0;
      wen_q <= '0;
      data_q <= '0;
      frz_q <= '0;
      apply_q <= 1'b0;
      wdog_err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= sync_d;
      mem_q <= mem_d;
      wp_q <= wp_d;
      rp_q <= rp_d;
      wdog_q <= wdog_d;
      wen_q <= wen_d;
      data_q <= data_d;
      frz_q <= frz_d;
      apply_q <= apply_d;
      wdog_err_q <= wdog_err_d;
      ovr_q <= ovr_d;
    end
  assign wen_o = wen_q;
  assign data_o = data_q;
  assign apply_o = apply_q;
  assign freeze_clk_o = frz_q;
  assign wdog_err_o = wdog_err_q;
  assign ovr_err_o = ovr_q;
endmodule
